// File: rtl/psum_out_drain_if.sv
// Handshake bundle between the psum drain and its neighbours: the core-side
// capture port and the chunked valid/ready output port.
interface psum_out_drain_if #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned out_bw  = 32
);
    logic                     in_valid;
    logic [psum_bw*col-1:0]   in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [out_bw-1:0]        out_data;
    logic                     out_last;

    // Environment side: drives core words and the consumer ready.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_last
    );

    // Drain side: accepts core words, presents chunks.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_last
    );
endinterface

// File: rtl/psum_out_drain.sv
// Buffers full-width core psum words in a small FIFO and serializes the head
// word into out_bw-bit chunks on a valid/ready port. Words arriving while the
// FIFO is full (and not popping) are dropped and flagged by a sticky overflow.
module psum_out_drain #(
    parameter int unsigned col     = 8,
    parameter int unsigned psum_bw = 16,
    parameter int unsigned out_bw  = 32,
    parameter int unsigned depth   = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    psum_out_drain_if.slave              bus,
    output logic [$clog2(depth+1)-1:0]   count,
    output logic                         full,
    output logic                         overflow
);
    localparam int unsigned W      = psum_bw * col;
    localparam int unsigned CHUNKS = W / out_bw;
    localparam int unsigned PW     = $clog2(depth);
    localparam int unsigned CW     = $clog2(depth + 1);
    localparam int unsigned IW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

    logic [W-1:0]                   r_mem [depth];
    logic [PW-1:0]                  r_wr_ptr;
    logic [PW-1:0]                  r_rd_ptr;
    logic [IW-1:0]                  r_idx;
    logic [CW-1:0]                  r_count;
    logic                           r_full;
    logic                           r_out_valid;
    logic                           r_overflow;

    logic [CHUNKS-1:0][out_bw-1:0]  w_head_chunks;
    logic                           w_last_idx;
    logic                           w_xfer;
    logic                           w_pop;
    logic                           w_push;
    logic                           w_ovf;
    logic [CW-1:0]                  w_count_nxt;

    // Handshake decode: a pop is the transfer of the last chunk of the head word.
    always_comb begin
        w_head_chunks = r_mem[r_rd_ptr];
        w_last_idx    = (r_idx == IW'(CHUNKS - 1));
        w_xfer        = r_out_valid && bus.out_ready;
        w_pop         = w_xfer && w_last_idx;
        w_push        = bus.in_valid && (!r_full || w_pop);
        w_ovf         = bus.in_valid && r_full && !w_pop;
        w_count_nxt   = r_count + CW'(w_push) - CW'(w_pop);
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_valid ? w_head_chunks[r_idx] : '0;
    assign bus.out_last  = r_out_valid && w_last_idx;
    assign count         = r_count;
    assign full          = r_full;
    assign overflow      = r_overflow;

    // FIFO storage; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (!reset && !clear && w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    // Pointers, chunk index, occupancy and flags; reset beats clear beats push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_idx       <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (clear) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_idx       <= '0;
            r_count     <= '0;
            r_full      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_xfer) begin
                r_idx <= w_last_idx ? '0 : r_idx + IW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
            r_count     <= w_count_nxt;
            r_full      <= (w_count_nxt == CW'(depth));
            r_out_valid <= (w_count_nxt != '0);
        end
    end
endmodule

// File: tb/tb_psum_out_drain.sv
// Directed bench for psum_out_drain at default parameters (4 chunks/word, depth 16).
module tb_psum_out_drain;
    logic       clk;
    logic       reset;
    logic       clear;
    logic [4:0] count;
    logic       full;
    logic       overflow;

    int n_checks = 0;
    int n_pass   = 0;

    psum_out_drain_if #(.col(8), .psum_bw(16), .out_bw(32)) bus ();

    psum_out_drain #(.col(8), .psum_bw(16), .out_bw(32), .depth(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .bus      (bus.slave),
        .count    (count),
        .full     (full),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running, required finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Column j of word s holds s*8+j, so every word and every chunk is distinct.
    function automatic logic [127:0] mk_word(input int s);
        logic [127:0] w;
        w = '0;
        for (int j = 0; j < 8; j++) w[j*16 +: 16] = 16'(s * 8 + j);
        return w;
    endfunction

    // Consumer is ready: one chunk per cycle, in order, last flag on chunk 3.
    task automatic expect_word(input string tag, input logic [127:0] w);
        for (int k = 0; k < 4; k++) begin
            chk({tag, " valid"}, 128'(bus.out_valid), 128'(1));
            chk({tag, " data"}, 128'(bus.out_data), 128'(w[k*32 +: 32]));
            chk({tag, " last"}, 128'(bus.out_last), 128'(k == 3));
            tick();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset         = 1'b1;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        do_reset();

        // Reset state
        chk("rst count", 128'(count), 128'(0));
        chk("rst full", 128'(full), 128'(0));
        chk("rst overflow", 128'(overflow), 128'(0));
        chk("rst out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst out_last", 128'(bus.out_last), 128'(0));
        chk("rst out_data", 128'(bus.out_data), 128'(0));

        // 1: single word, consumer always ready
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
        tick();
        bus.in_valid  = 1'b0;
        chk("t1 count", 128'(count), 128'(1));
        chk("t1 valid c0", 128'(bus.out_valid), 128'(1));
        chk("t1 chunk0", 128'(bus.out_data), 128'(32'h0001_0000));
        chk("t1 last c0", 128'(bus.out_last), 128'(0));
        tick();
        chk("t1 chunk1", 128'(bus.out_data), 128'(32'h0003_0002));
        chk("t1 last c1", 128'(bus.out_last), 128'(0));
        tick();
        chk("t1 chunk2", 128'(bus.out_data), 128'(32'h0005_0004));
        chk("t1 last c2", 128'(bus.out_last), 128'(0));
        tick();
        chk("t1 chunk3", 128'(bus.out_data), 128'(32'h0007_0006));
        chk("t1 last c3", 128'(bus.out_last), 128'(1));
        tick();
        chk("t1 count end", 128'(count), 128'(0));
        chk("t1 valid end", 128'(bus.out_valid), 128'(0));
        chk("t1 data end", 128'(bus.out_data), 128'(0));

        // 2: backpressure holds chunk 0 stable
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = mk_word(1);
        tick();
        bus.in_valid  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("t2 stall valid", 128'(bus.out_valid), 128'(1));
            chk("t2 stall data", 128'(bus.out_data), 128'(32'h0009_0008));
            tick();
        end
        bus.out_ready = 1'b1;
        expect_word("t2 drain", mk_word(1));
        chk("t2 count end", 128'(count), 128'(0));

        // 3: fill 16, 17th overflows, drain exactly words 1..16
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 17; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mk_word(10 + i);
            tick();
            if (i == 15) chk("t3 not full at 15", 128'(full), 128'(0));
            if (i == 16) begin
                chk("t3 full at 16", 128'(full), 128'(1));
                chk("t3 count at 16", 128'(count), 128'(16));
                chk("t3 no ovf at 16", 128'(overflow), 128'(0));
            end
        end
        bus.in_valid = 1'b0;
        chk("t3 overflow", 128'(overflow), 128'(1));
        chk("t3 count after drop", 128'(count), 128'(16));
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) expect_word("t3 drain", mk_word(10 + i));
        chk("t3 count end", 128'(count), 128'(0));
        chk("t3 overflow sticky", 128'(overflow), 128'(1));

        // 4: full FIFO, push in the cycle the head's last chunk transfers
        do_reset();
        chk("t4 ovf after reset", 128'(overflow), 128'(0));
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mk_word(100 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("t4 full", 128'(full), 128'(1));
        bus.out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("t4 at last chunk", 128'(bus.out_last), 128'(1));
        bus.in_valid = 1'b1;
        bus.in_data  = mk_word(200);
        tick();
        bus.in_valid = 1'b0;
        chk("t4 count stays", 128'(count), 128'(16));
        chk("t4 full stays", 128'(full), 128'(1));
        chk("t4 no overflow", 128'(overflow), 128'(0));
        for (int i = 1; i < 16; i++) expect_word("t4 drain", mk_word(100 + i));
        expect_word("t4 drain new", mk_word(200));
        chk("t4 count end", 128'(count), 128'(0));

        // 5: 40 words at one per 4 cycles, pointers wrap
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = mk_word(300);
        tick();
        bus.in_valid  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [127:0] w;
            w = mk_word(300 + i);
            for (int k = 0; k < 4; k++) begin
                if (k == 3 && i < 39) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = mk_word(301 + i);
                end
                chk("t5 data", 128'(bus.out_data), 128'(w[k*32 +: 32]));
                chk("t5 last", 128'(bus.out_last), 128'(k == 3));
                chk("t5 count", 128'(count), 128'(1));
                tick();
                bus.in_valid = 1'b0;
            end
        end
        chk("t5 count end", 128'(count), 128'(0));
        chk("t5 valid end", 128'(bus.out_valid), 128'(0));
        chk("t5 overflow", 128'(overflow), 128'(0));

        // 6a: clear mid-word; word presented with clear is dropped silently
        bus.in_valid = 1'b1;
        bus.in_data  = mk_word(400);
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("t6 chunk2 before clear", 128'(bus.out_data), 128'(32'h0c85_0c84));
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = mk_word(401);
        tick();
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        chk("t6 clear valid", 128'(bus.out_valid), 128'(0));
        chk("t6 clear count", 128'(count), 128'(0));
        chk("t6 clear data", 128'(bus.out_data), 128'(0));
        chk("t6 clear no ovf", 128'(overflow), 128'(0));
        bus.in_valid = 1'b1;
        bus.in_data  = mk_word(402);
        tick();
        bus.in_valid = 1'b0;
        expect_word("t6 after clear", mk_word(402));

        // 6b: reset mid-word with overflow set
        bus.out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = mk_word(450 + i);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("t6 ovf before reset", 128'(overflow), 128'(1));
        bus.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6 rst count", 128'(count), 128'(0));
        chk("t6 rst full", 128'(full), 128'(0));
        chk("t6 rst overflow", 128'(overflow), 128'(0));
        chk("t6 rst valid", 128'(bus.out_valid), 128'(0));
        chk("t6 rst last", 128'(bus.out_last), 128'(0));
        chk("t6 rst data", 128'(bus.out_data), 128'(0));
        tick();
        chk("t6 idle after rst", 128'(bus.out_valid), 128'(0));
        bus.in_valid = 1'b1;
        bus.in_data  = mk_word(500);
        tick();
        bus.in_valid = 1'b0;
        expect_word("t6 after reset", mk_word(500));
        chk("t6 final count", 128'(count), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
